// File: rtl/fwrisc_mem_arbiter_pkg.sv
// Shared types for the FWRISC single-port SRAM arbiter: FSM states, grant encoding, read strobe.
// No logic; latency and backpressure are defined by the modules that import it.
package fwrisc_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam logic [3:0] RD_STB = 4'hf;

endpackage

// File: rtl/fwrisc_mem_arbiter_if.sv
// Bundle of fetch port, data port and SRAM port signals seen by the arbiter.
// slave = arbiter side; master = core plus SRAM side.
interface fwrisc_mem_arbiter_if #(
    parameter int ADR_WIDTH = 22
);
    logic                 i_valid;
    logic [31:0]          i_addr;
    logic                 i_ready;
    logic [31:0]          i_rdata;

    logic                 d_valid;
    logic [31:0]          d_addr;
    logic [31:0]          d_wdata;
    logic [3:0]           d_wstb;
    logic                 d_write;
    logic                 d_ready;
    logic [31:0]          d_rdata;

    logic                 m_en;
    logic                 m_we;
    logic [ADR_WIDTH-1:0] m_adr;
    logic [3:0]           m_sel;
    logic [31:0]          m_dat_w;
    logic [31:0]          m_dat_r;

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstb, d_write, m_dat_r,
        output i_ready, i_rdata, d_ready, d_rdata, m_en, m_we, m_adr, m_sel, m_dat_w
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstb, d_write, m_dat_r,
        input  i_ready, i_rdata, d_ready, d_rdata, m_en, m_we, m_adr, m_sel, m_dat_w
    );
endinterface

// File: rtl/fwrisc_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker (bit 0 = fetch, bit 1 = data); grant is combinational, zero latency.
// Pointer only moves on a contended grant and then points at the loser, so neither side starves.
module fwrisc_rr_arb2 #(
    parameter int INIT_PRIO_D = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_upd_en,
    output logic [1:0] o_gnt
);
    logic       r_ptr_d;
    logic [1:0] w_elig;
    logic       w_contend;

    assign w_elig    = i_req & ~i_mask;
    assign w_contend = &w_elig;

    // Without contention at most one bit of w_elig is set, so it is already one-hot.
    assign o_gnt = w_contend ? (r_ptr_d ? 2'b10 : 2'b01) : w_elig;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr_d <= (INIT_PRIO_D != 0);
        end else if (i_upd_en && w_contend) begin
            r_ptr_d <= ~r_ptr_d;
        end
    end
endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Shares one single-port SRAM between FWRISC fetch and data ports; grant drives SRAM in cycle G, ready pulses in G+1.
// A port is held off only while the other owns the SRAM; one access per cycle under contention, alternating I/D.
module fwrisc_mem_arbiter
    import fwrisc_mem_arbiter_pkg::*;
#(
    parameter int         ADR_WIDTH   = 22,
    parameter logic [3:0] MEM_REGION  = 4'h8,
    parameter int         INIT_PRIO_D = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    fwrisc_mem_arbiter_if.slave bus
);
    state_t     r_state;
    logic       r_i_ready;
    logic       r_d_ready;
    logic       r_d_inreg;

    logic [1:0] w_req;
    logic [1:0] w_mask;
    logic [1:0] w_gnt;
    gnt_t       w_gnt_e;
    logic       w_d_inreg;
    logic       w_unused_addr;

    // Grants are suppressed during reset so no SRAM cycle is issued for an abandoned request.
    assign w_req     = {bus.d_valid, bus.i_valid} & {2{reset_n}};
    assign w_mask    = {r_state == D_ACC, r_state == I_ACC};
    assign w_d_inreg = (bus.d_addr[31:28] == MEM_REGION);

    fwrisc_rr_arb2 #(
        .INIT_PRIO_D (INIT_PRIO_D)
    ) u_rr (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_req    (w_req),
        .i_mask   (w_mask),
        .i_upd_en (1'b1),
        .o_gnt    (w_gnt)
    );

    always_comb begin
        w_gnt_e = GNT_NONE;
        if (w_gnt[0]) begin
            w_gnt_e = GNT_I;
        end else if (w_gnt[1]) begin
            w_gnt_e = GNT_D;
        end
    end

    always_comb begin
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_sel   = '0;
        bus.m_adr   = '0;
        bus.m_dat_w = '0;
        case (w_gnt_e)
            GNT_I: begin
                bus.m_en  = 1'b1;
                bus.m_sel = RD_STB;
                bus.m_adr = bus.i_addr[ADR_WIDTH+1:2];
            end
            GNT_D: begin
                bus.m_adr = bus.d_addr[ADR_WIDTH+1:2];
                if (w_d_inreg) begin
                    bus.m_en = 1'b1;
                    if (bus.d_write) begin
                        bus.m_we    = 1'b1;
                        bus.m_sel   = bus.d_wstb;
                        bus.m_dat_w = bus.d_wdata;
                    end else begin
                        bus.m_sel = RD_STB;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_d_inreg <= 1'b0;
        end else begin
            r_i_ready <= (w_gnt_e == GNT_I);
            r_d_ready <= (w_gnt_e == GNT_D);
            r_d_inreg <= w_d_inreg;
            case (w_gnt_e)
                GNT_I:   r_state <= I_ACC;
                GNT_D:   r_state <= D_ACC;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_ready = r_i_ready;
    assign bus.d_ready = r_d_ready;
    // SRAM read data is already registered, so it lines up with the ready pulse.
    assign bus.i_rdata = r_i_ready ? bus.m_dat_r : 32'h0;
    assign bus.d_rdata = (r_d_ready && r_d_inreg) ? bus.m_dat_r : 32'h0;

    assign w_unused_addr = ^{bus.i_addr, bus.d_addr};
endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed bench for fwrisc_mem_arbiter with a behavioural byte-enabled SRAM behind it.
module tb_fwrisc_mem_arbiter;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    fwrisc_mem_arbiter_if #(.ADR_WIDTH(22)) bus ();

    fwrisc_mem_arbiter #(
        .ADR_WIDTH   (22),
        .MEM_REGION  (4'h8),
        .INIT_PRIO_D (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [256];
    logic [31:0] r_rd;

    always @(posedge clock) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_sel[b]) mem[bus.m_adr[7:0]][8*b +: 8] <= bus.m_dat_w[8*b +: 8];
            end else begin
                r_rd <= mem[bus.m_adr[7:0]];
            end
        end
    end
    assign bus.m_dat_r = r_rd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Entered and left at posedge+1 of an idle cycle.
    task automatic d_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstb,
                          input logic write, output logic en, output logic we, output logic [3:0] sel,
                          output logic [21:0] adr, output logic [31:0] datw, output logic rdy,
                          output logic [31:0] rdata);
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_wstb  = wstb;
        bus.d_write = write;
        bus.d_valid = 1'b1;
        #1;
        en = bus.m_en; we = bus.m_we; sel = bus.m_sel; adr = bus.m_adr; datw = bus.m_dat_w;
        step();
        rdy = bus.d_ready; rdata = bus.d_rdata;
        bus.d_valid = 1'b0;
        step();
    endtask

    logic        en, we, rdy, prev_d, is_d;
    logic [3:0]  sel;
    logic [21:0] adr;
    logic [31:0] datw, rdata;

    initial begin
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h8000_0010;
        bus.d_valid = 1'b1;
        bus.d_addr  = 32'h8000_0020;
        bus.d_wdata = 32'hAABB_CCDD;
        bus.d_wstb  = 4'hf;
        bus.d_write = 1'b1;

        step(); step(); #1;
        chk("rst_i_ready", 32'(bus.i_ready), 32'h0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'h0);
        chk("rst_m_en",    32'(bus.m_en),    32'h0);
        chk("rst_m_we",    32'(bus.m_we),    32'h0);
        chk("rst_m_sel",   32'(bus.m_sel),   32'h0);
        chk("rst_m_adr",   32'(bus.m_adr),   32'h0);
        chk("rst_m_dat_w", bus.m_dat_w,      32'h0);
        chk("rst_i_rdata", bus.i_rdata,      32'h0);
        chk("rst_d_rdata", bus.d_rdata,      32'h0);

        // Both ports held from reset: D first, then strict alternation.
        reset_n = 1'b1;
        #1;
        prev_d = 1'b0;
        for (int k = 0; k < 8; k++) begin
            is_d = (k % 2 == 0);
            chk("rr_adr", 32'(bus.m_adr), is_d ? 32'd8 : 32'd4);
            chk("rr_we",  32'(bus.m_we),  32'(is_d));
            if (k > 0) begin
                chk("rr_i_ready", 32'(bus.i_ready), 32'(!prev_d));
                chk("rr_d_ready", 32'(bus.d_ready), 32'(prev_d));
            end
            prev_d = is_d;
            step(); #1;
        end
        chk("rr_last_i_ready", 32'(bus.i_ready), 32'h1);
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        step();

        d_xfer(32'h8000_0010, 32'hDEAD_BEEF, 4'hf, 1'b1, en, we, sel, adr, datw, rdy, rdata);
        chk("wr4_we",  32'(we),  32'h1);
        chk("wr4_adr", 32'(adr), 32'd4);
        chk("wr4_rdy", 32'(rdy), 32'h1);

        bus.i_addr  = 32'h8000_0010;
        bus.i_valid = 1'b1;
        #1;
        chk("fetch_en",  32'(bus.m_en),  32'h1);
        chk("fetch_adr", 32'(bus.m_adr), 32'd4);
        chk("fetch_sel", 32'(bus.m_sel), 32'hf);
        step();
        chk("fetch_rdy",   32'(bus.i_ready), 32'h1);
        chk("fetch_rdata", bus.i_rdata,      32'hDEAD_BEEF);
        bus.i_valid = 1'b0;
        step();

        d_xfer(32'h8000_0020, 32'h1122_3344, 4'b0101, 1'b1, en, we, sel, adr, datw, rdy, rdata);
        chk("wstb_sel",  32'(sel), 32'h5);
        chk("wstb_datw", datw,     32'h1122_3344);
        chk("wstb_rdy",  32'(rdy), 32'h1);

        d_xfer(32'h8000_0020, 32'h0, 4'h0, 1'b0, en, we, sel, adr, datw, rdy, rdata);
        chk("rd8_sel",   32'(sel), 32'hf);
        chk("rd8_we",    32'(we),  32'h0);
        chk("rd8_rdata", rdata,    32'hAA22_CC44);

        d_xfer(32'h4000_0000, 32'h0, 4'h0, 1'b0, en, we, sel, adr, datw, rdy, rdata);
        chk("oor_en",    32'(en),  32'h0);
        chk("oor_rdy",   32'(rdy), 32'h1);
        chk("oor_rdata", rdata,    32'h0);

        bus.i_addr  = 32'h8000_0010;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("b2b_en",    32'(bus.m_en),    32'(k % 2 == 0));
            chk("b2b_ready", 32'(bus.i_ready), 32'(k % 2 == 1));
            if (k % 2 == 1) chk("b2b_rdata", bus.i_rdata, 32'hDEAD_BEEF);
            step();
        end
        bus.i_valid = 1'b0;
        step();

        // Reset lands on the edge that would complete a D read.
        bus.d_addr  = 32'h8000_0020;
        bus.d_write = 1'b0;
        bus.d_valid = 1'b1;
        #1;
        chk("mid_gnt_en", 32'(bus.m_en), 32'h1);
        reset_n = 1'b0;
        step();
        chk("mid_d_ready", 32'(bus.d_ready), 32'h0);
        chk("mid_m_en",    32'(bus.m_en),    32'h0);
        chk("mid_d_rdata", bus.d_rdata,      32'h0);
        bus.d_valid = 1'b0;
        step();
        reset_n = 1'b1;
        bus.i_addr  = 32'h8000_0010;
        bus.i_valid = 1'b1;
        bus.d_valid = 1'b1;
        #1;
        chk("post_rst_gnt", 32'(bus.m_adr), 32'd8);
        step();
        chk("post_rst_d_ready", 32'(bus.d_ready), 32'h1);
        chk("post_rst_d_rdata", bus.d_rdata,      32'hAA22_CC44);
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fwrisc_mem_arbiter.md
Name: fwrisc_mem_arbiter

Overview:
Shares one single-port, byte-enabled synchronous SRAM between the FWRISC core instruction-fetch port and data port. It replaces the dual-port SRAM arrangement used for unit-level runs and is the memory front end for single-port FPGA/ASIC integrations. Requests are granted round-robin when both ports contend. Data accesses outside the SRAM region complete without touching memory.

Parameters:
ADR_WIDTH, 22, SRAM word-address width (16 MB).
MEM_REGION, 4'h8, value of d_addr[31:28] that selects the SRAM for data accesses.
INIT_PRIO_D, 1, port that wins the first contended arbitration after reset (1 = data, 0 = instruction).

Ports:
clock  in  1  the block's only clock; all logic on posedge.
reset_n  in  1  synchronous, active-low reset.
i_valid  in  1  instruction fetch request; held until i_ready.
i_addr  in  32  fetch byte address; bits [1:0] ignored.
i_ready  out  1  single-cycle pulse: fetch complete.
i_rdata  out  32  fetch data; valid only while i_ready=1.
d_valid  in  1  data request; held with its fields until d_ready.
d_addr  in  32  data byte address.
d_wdata  in  32  write data.
d_wstb  in  4  byte strobes for writes.
d_write  in  1  1 = write, 0 = read.
d_ready  out  1  single-cycle pulse: data access complete.
d_rdata  out  32  read data; valid only while d_ready=1.
m_en  out  1  SRAM access enable.
m_we  out  1  SRAM write enable.
m_adr  out  ADR_WIDTH  SRAM word address (addr[ADR_WIDTH+1:2]).
m_sel  out  4  SRAM byte enables (4'hf for reads).
m_dat_w  out  32  SRAM write data.
m_dat_r  in  32  SRAM read data, registered, valid one cycle after m_en.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; i_ready=d_ready=0, m_en=m_we=0, m_sel=0, m_adr=0, m_dat_w=0, i_rdata=d_rdata=0. The round-robin pointer is loaded from INIT_PRIO_D. Any in-flight access is abandoned, and no ready pulse is issued for it.
- States: IDLE, I_ACC, D_ACC. The ACC states are the completion cycle of a grant made in the previous cycle.
- Grant cycle G (combinational drive of the m_* outputs):
  - The chosen request drives m_adr.
  - For a D write in the SRAM region: m_en=1, m_we=1, m_sel=d_wstb, m_dat_w=d_wdata.
  - For reads: m_we=0, m_sel=4'hf.
  - For a D access with d_addr[31:28]!=MEM_REGION: no m_en.
- Completion cycle G+1: the corresponding ready=1.
  - Reads return rdata=m_dat_r, or 0 for out-of-region accesses.
  - Write latency is also 1 cycle.
  - Fixed latency: request seen in an idle cycle -> ready exactly one cycle later.
- Eligibility rule: during X_ACC, port X's valid is still its finished request, so X is ineligible that cycle. Only the other port may be granted, which overlaps with the completion.
- Transitions:
  - IDLE: neither valid -> IDLE. Only one valid -> grant it (I_ACC/D_ACC). Both valid -> grant the pointer's port.
  - I_ACC: d_valid -> D_ACC; else IDLE.
  - D_ACC: i_valid -> I_ACC; else IDLE.
- Pointer update: on every contended grant, the pointer moves to the non-granted port. Uncontended grants leave it unchanged. Result: sustained dual contention alternates I,D,I,D at one access per cycle, with no starvation.
- A single port issuing back-to-back requests gets one access per 2 cycles (grant, complete/idle).
- Read-after-write ordering follows grant order; no forwarding is needed because the SRAM is single-port and sequential.
- Valid dropping before ready is illegal. If it happens, the in-flight access still completes with a ready pulse.

Decomposition:
- Package fwrisc_mem_arbiter_pkg holds:
  - the state enum (IDLE, I_ACC, D_ACC);
  - the grant enum (GNT_NONE, GNT_I, GNT_D);
  - a localparam for the read-strobe value 4'hf.
- Sub-module fwrisc_rr_arb2: 2-requester round-robin picker.
  - Inputs: req[1:0], mask[1:0], a pointer-update enable.
  - Outputs: the one-hot grant.
  - Owns the pointer register and reset value.

Test Plan:
- Only i_valid, i_addr=0x80000010, SRAM word 4=0xDEADBEEF -> m_en at cycle 0 with m_adr=4; i_ready at cycle 1, i_rdata=0xDEADBEEF.
- D write d_addr=0x80000020, wdata=0x11223344, wstb=4'b0101, then D read of the same address -> SRAM word 8 bytes 0 and 2 updated; read returns 0xXX22XX44 with the original bytes 1 and 3 preserved.
- Both valid from reset, INIT_PRIO_D=1, held continuously for 8 grants -> grant order D,I,D,I,...; one ready per cycle after the first; no port waits more than 1 grant.
- d_addr=0x40000000 read -> m_en stays 0; d_ready at cycle 1, d_rdata=0.
- reset_n low in the cycle after a D grant -> no d_ready; all outputs 0 next cycle; the first contended grant after release goes to D.
- I requests back-to-back alone -> i_ready every other cycle; m_en pattern 1,0,1,0.
